// File: rtl/sha2_msg_schedule.sv
`timescale 1ns/1ps
// SHA-2 message schedule producer: passes M_0..M_15 straight through, then
// expands W_16..W_(R-1) from a 16-word sliding window, one word per handshake.
module sha2_msg_schedule #(
    parameter int WIDTH = 32,
    parameter int MODE  = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] m_data,
    input  logic             m_valid,
    output logic             m_ready,
    output logic [WIDTH-1:0] w_data,
    output logic [6:0]       w_idx,
    output logic             w_last,
    output logic             w_valid,
    input  logic             w_ready
);
    localparam bit         WIDE   = (MODE == 384) || (MODE == 512);
    localparam int         ROUNDS = WIDE ? 80 : 64;
    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);
    localparam int         S0_A   = WIDE ? 1  : 7;
    localparam int         S0_B   = WIDE ? 8  : 18;
    localparam int         S0_S   = WIDE ? 7  : 3;
    localparam int         S1_A   = WIDE ? 19 : 17;
    localparam int         S1_B   = WIDE ? 61 : 19;
    localparam int         S1_S   = WIDE ? 6  : 10;

    localparam logic [0:0] LOAD   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    logic [0:0]       state;
    logic [6:0]       t;
    logic             running;
    logic [WIDTH-1:0] win [0:15];
    logic             adv;
    logic             m_fire;
    logic [WIDTH-1:0] expand_word;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction

    function automatic logic [WIDTH-1:0] sig0(input logic [WIDTH-1:0] x);
        return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_S);
    endfunction

    function automatic logic [WIDTH-1:0] sig1(input logic [WIDTH-1:0] x);
        return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_S);
    endfunction

    // running keeps m_ready low until the first edge after reset release
    always_comb begin
        adv         = !w_valid || w_ready;
        m_ready     = running && (state == LOAD) && adv;
        m_fire      = m_valid && m_ready;
        expand_word = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            t       <= '0;
            running <= 1'b0;
            w_data  <= '0;
            w_idx   <= '0;
            w_last  <= 1'b0;
            w_valid <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            running <= 1'b1;
            if (clr) begin
                state   <= LOAD;
                t       <= '0;
                w_valid <= 1'b0;
                w_last  <= 1'b0;
            end else if (state == LOAD) begin
                if (m_fire) begin
                    w_data  <= m_data;
                    w_idx   <= t;
                    w_last  <= 1'b0;
                    w_valid <= 1'b1;
                    for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                    win[15] <= m_data;
                    t       <= t + 7'd1;
                    if (t == 7'd15) state <= EXPAND;
                end else if (adv) begin
                    w_valid <= 1'b0;
                end
            end else if (adv) begin
                // w_last implies w_valid, so adv here means the final word was taken
                if (w_last) begin
                    state   <= LOAD;
                    t       <= '0;
                    w_valid <= 1'b0;
                    w_last  <= 1'b0;
                end else begin
                    w_data  <= expand_word;
                    w_idx   <= t;
                    w_last  <= (t == LAST_T);
                    w_valid <= 1'b1;
                    for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                    win[15] <= expand_word;
                    t       <= t + 7'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sha2_msg_schedule.sv
`timescale 1ns/1ps
// Bench for sha2_msg_schedule: random blocks and w_ready patterns are compared
// every cycle against a plain-arithmetic SHA-2 schedule model.
module tb_sha2_msg_schedule;
    typedef logic [63:0] blk_t [16];
    typedef logic [63:0] sch_t [80];
    typedef struct {
        logic [63:0] data;
        int          idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] w_data;
    logic [6:0]  w_idx;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;

    logic [63:0] m2_data;
    logic        m2_valid;
    logic        m2_ready;
    logic [63:0] w2_data;
    logic [6:0]  w2_idx;
    logic        w2_last;
    logic        w2_valid;
    logic        w2_ready = 1'b1;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    blk_t cur_blk;
    sch_t mon_sched;
    int   acc_cnt = 0;
    int   cyc = 0;
    int   last_end_cyc = -100;
    int   gap = 0;
    int   blocks_done = 0;
    int   stall_en = 0;
    int   rand_ready = 0;
    int   stall_left = 0;
    int   last_stall_idx = -1;
    logic [63:0] got512 [80];
    int   last512 = -1;
    int   cnt512 = 0;

    sha2_msg_schedule #(.WIDTH(32), .MODE(256)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .w_data(w_data), .w_idx(w_idx), .w_last(w_last),
        .w_valid(w_valid), .w_ready(w_ready)
    );

    sha2_msg_schedule #(.WIDTH(64), .MODE(512)) dut512 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .m_data(m2_data), .m_valid(m2_valid), .m_ready(m2_ready),
        .w_data(w2_data), .w_idx(w2_idx), .w_last(w2_last),
        .w_valid(w2_valid), .w_ready(w2_ready)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rot(input logic [63:0] x, input int n, input int wd);
        logic [63:0] mask;
        mask = (wd == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return ((x >> n) | (x << (wd - n))) & mask;
    endfunction

    // Textbook SHA-2 schedule recurrence over a whole block
    function automatic void model_schedule(input blk_t m, input bit is64, output sch_t w);
        logic [63:0] mask, s0, s1;
        int r;
        mask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        r    = is64 ? 80 : 64;
        for (int k = 0; k < 80; k++) w[k] = '0;
        for (int k = 0; k < 16; k++) w[k] = m[k] & mask;
        for (int k = 16; k < r; k++) begin
            if (is64) begin
                s0 = rot(w[k-15], 1, 64) ^ rot(w[k-15], 8, 64) ^ (w[k-15] >> 7);
                s1 = rot(w[k-2], 19, 64) ^ rot(w[k-2], 61, 64) ^ (w[k-2] >> 6);
            end else begin
                s0 = rot(w[k-15], 7, 32) ^ rot(w[k-15], 18, 32) ^ (w[k-15] >> 3);
                s1 = rot(w[k-2], 17, 32) ^ rot(w[k-2], 19, 32) ^ (w[k-2] >> 10);
            end
            w[k] = (s1 + w[k-7] + s0 + w[k-16]) & mask;
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            acc_cnt = 0;
        end else begin
            if (w_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("w_valid_unexpected", {63'b0, w_valid}, 64'd0);
                end else begin
                    check_output("w_data", {32'b0, w_data}, exp_q[0].data);
                    check_output("w_idx", 64'(w_idx), 64'(exp_q[0].idx));
                    check_output("w_last", {63'b0, w_last}, {63'b0, (exp_q[0].idx == 63)});
                    if (!w_ready) check_output("m_ready_stall", {63'b0, m_ready}, 64'd0);
                    if (w_ready) begin
                        if (exp_q[0].idx == 63) begin
                            blocks_done++;
                            last_end_cyc = cyc;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (clr) begin
                exp_q.delete();
                acc_cnt = 0;
            end else if (m_valid && m_ready) begin
                if (acc_cnt == 0) gap = cyc - last_end_cyc;
                cur_blk[acc_cnt] = {32'b0, m_data};
                exp_q.push_back('{data: {32'b0, m_data}, idx: acc_cnt});
                acc_cnt++;
                if (acc_cnt == 16) begin
                    model_schedule(cur_blk, 1'b0, mon_sched);
                    for (int k = 16; k < 64; k++) exp_q.push_back('{data: mon_sched[k], idx: k});
                    acc_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && w2_valid && w2_ready) begin
            if (w2_idx < 7'd80) got512[w2_idx] = w2_data;
            if (w2_last) last512 = int'(w2_idx);
            cnt512++;
        end
    end

    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                w_ready = 1'b0;
                stall_left--;
            end else if (stall_en != 0 && w_valid && (w_idx == 7'd3 || w_idx == 7'd40)
                         && int'(w_idx) != last_stall_idx) begin
                w_ready        = 1'b0;
                stall_left     = 4;
                last_stall_idx = int'(w_idx);
            end else if (rand_ready != 0) begin
                w_ready = ($urandom_range(0, 3) != 0);
            end else begin
                w_ready = 1'b1;
            end
        end
    end

    task automatic apply_stimulus(input blk_t blk, input int n, input bit hold);
        bit got;
        int waited;
        for (int i = 0; i < n; i++) begin
            m_data  = blk[i][31:0];
            m_valid = 1'b1;
            got     = 1'b0;
            waited  = 0;
            while (!got && waited < 400) begin
                @(negedge clk);
                got = m_ready && !clr;
                @(posedge clk);
                #1;
                waited++;
            end
            if (!got) begin
                check_output("m_accept_timeout", {63'b0, got}, 64'd1);
                m_valid = 1'b0;
                return;
            end
        end
        if (!hold) m_valid = 1'b0;
    endtask

    task automatic wait_blocks(input int n);
        int waited;
        waited = 0;
        while (blocks_done < n && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check_output("blocks_done", 64'(blocks_done), 64'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int k);
        int waited;
        bit found;
        waited = 0;
        found  = 1'b0;
        while (!found && waited < 300) begin
            @(negedge clk);
            found = w_valid && (int'(w_idx) == k);
            waited++;
        end
        check_output("reach_idx", {63'b0, found}, 64'd1);
    endtask

    function automatic blk_t random_block();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = 64'($urandom);
        return b;
    endfunction

    initial begin
        blk_t b, b2;
        sch_t ref_w;
        bit   got;
        int   waited;

        rst_n = 1'b0; clr = 1'b0;
        m_valid = 1'b0; m_data = '0;
        m2_valid = 1'b0; m2_data = '0;

        // Published "abc" schedule words pin the model itself
        for (int i = 0; i < 16; i++) b[i] = '0;
        b[0] = 64'h6162_6380; b[15] = 64'h18;
        model_schedule(b, 1'b0, ref_w);
        check_output("model256_w16", ref_w[16], 64'h6162_6380);
        check_output("model256_w17", ref_w[17], 64'h000F_0000);
        check_output("model256_w18", ref_w[18], 64'h7DA8_6405);
        b2 = b;
        b2[0] = 64'h6162_6380_0000_0000;
        model_schedule(b2, 1'b1, ref_w);
        check_output("model512_w16", ref_w[16], 64'h6162_6380_0000_0000);
        check_output("model512_w17", ref_w[17], 64'h0003_0000_0000_00C0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_w_valid", {63'b0, w_valid}, 64'd0);
        check_output("reset_w_data", {32'b0, w_data}, 64'd0);
        check_output("reset_w_idx", 64'(w_idx), 64'd0);
        check_output("reset_w_last", {63'b0, w_last}, 64'd0);
        check_output("reset_m_ready", {63'b0, m_ready}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("m_ready_before_first_edge", {63'b0, m_ready}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("m_ready_after_release", {63'b0, m_ready}, 64'd1);
        @(posedge clk); #1;

        $display("[TB] abc block, w_ready high");
        apply_stimulus(b, 16, 1'b0);
        @(negedge clk);
        check_output("m_ready_in_expand", {63'b0, m_ready}, 64'd0);
        wait_blocks(1);

        $display("[TB] stalls at t=3 and t=40");
        stall_en = 1;
        b = random_block();
        apply_stimulus(b, 16, 1'b0);
        wait_blocks(2);
        stall_en = 0;

        $display("[TB] random w_ready");
        rand_ready = 1;
        b = random_block();
        apply_stimulus(b, 16, 1'b0);
        wait_blocks(3);
        rand_ready = 0;

        $display("[TB] back-to-back blocks");
        b  = random_block();
        b2 = random_block();
        apply_stimulus(b, 16, 1'b1);
        apply_stimulus(b2, 16, 1'b0);
        wait_blocks(5);
        check_output("b2b_gap", 64'(gap), 64'd1);

        $display("[TB] async reset mid-expand");
        b = random_block();
        apply_stimulus(b, 16, 1'b0);
        wait_idx(30);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_output("w_valid_async_reset", {63'b0, w_valid}, 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        b = random_block();
        apply_stimulus(b, 16, 1'b0);
        wait_blocks(6);

        $display("[TB] clr during load");
        b = random_block();
        apply_stimulus(b, 11, 1'b0);
        clr = 1'b1; m_valid = 1'b1; m_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        clr = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        check_output("clr_load_w_valid", {63'b0, w_valid}, 64'd0);
        check_output("clr_load_m_ready", {63'b0, m_ready}, 64'd1);
        @(posedge clk); #1;
        b = random_block();
        apply_stimulus(b, 16, 1'b0);
        wait_blocks(7);

        $display("[TB] clr during expand");
        b = random_block();
        apply_stimulus(b, 16, 1'b0);
        wait_idx(50);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check_output("clr_expand_w_valid", {63'b0, w_valid}, 64'd0);
        check_output("clr_expand_w_last", {63'b0, w_last}, 64'd0);
        check_output("clr_expand_m_ready", {63'b0, m_ready}, 64'd1);
        @(posedge clk); #1;
        b = random_block();
        apply_stimulus(b, 16, 1'b0);
        wait_blocks(8);
        check_output("exp_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] SHA-512 abc block");
        for (int i = 0; i < 16; i++) b[i] = '0;
        b[0] = 64'h6162_6380_0000_0000; b[15] = 64'h18;
        for (int i = 0; i < 16; i++) begin
            m2_data  = b[i];
            m2_valid = 1'b1;
            got      = 1'b0;
            waited   = 0;
            while (!got && waited < 100) begin
                @(negedge clk);
                got = m2_ready;
                @(posedge clk); #1;
                waited++;
            end
        end
        m2_valid = 1'b0;
        waited = 0;
        while (cnt512 < 80 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        model_schedule(b, 1'b1, ref_w);
        check_output("w512_count", 64'(cnt512), 64'd80);
        check_output("w512_last_idx", 64'(last512), 64'd79);
        for (int k = 0; k < 80; k++) check_output($sformatf("w512_%0d", k), got512[k], ref_w[k]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/sha2_msg_schedule.md
Name: sha2_msg_schedule

Overview:
- Producer side of the W interface consumed by the SHA-2 compression round.
- Accepts one 16-word message block over a valid/ready stream and emits the full schedule W_0..W_(R-1), one word per handshake.
- W_0..W_15 pass straight through; the remaining words are expanded on the fly from a 16-word sliding window.
- Sits between the padding/block buffer and the round datapath of the EdDSA hash core.

Parameters:
- WIDTH, 32, word width: 32 for MODE 224/256, 64 for MODE 384/512.
- MODE, 256, SHA-2 variant: 224, 256, 384 or 512. Selects sigma functions and round count R (64 for 224/256, 80 for 384/512).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: drop the current block and return to LOAD.
- m_data  in  WIDTH  message word M_t, big-endian word order, t=0..15.
- m_valid  in  1  m_data valid.
- m_ready  out  1  block accepts m_data this cycle.
- w_data  out  WIDTH  schedule word W_t.
- w_idx  out  7  round index t of w_data.
- w_last  out  1  high when w_idx == R-1.
- w_valid  out  1  w_data valid.
- w_ready  in  1  round datapath accepts w_data.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD, counter t=0, window cleared to 0.
  - w_valid=0, w_data=0, w_idx=0, w_last=0, m_ready=0 until the first clock edge after release.
- Output register: single stage.
  - adv = !w_valid | w_ready.
  - Registered outputs hold stable while w_valid=1 and w_ready=0.
- Window W[0..15]: W[15] is the newest word. Each accepted or generated word shifts in at W[15]; W[0] is discarded.
- State LOAD (t<16):
  - m_ready = adv (combinational).
  - On m_valid & m_ready: w_data<=m_data, w_idx<=t, w_valid<=1, shift m_data into window, t<=t+1.
  - After the t=15 word is accepted, go to EXPAND.
  - If adv and no m_valid: w_valid<=0.
- State EXPAND (16<=t<R):
  - m_ready=0.
  - When adv: new = s1(W[14]) + W[9] + s0(W[1]) + W[0], mod 2^WIDTH (wrap, no carry out). Here W[14]=W_(t-2), W[9]=W_(t-7), W[1]=W_(t-15), W[0]=W_(t-16).
  - Register new as w_data with w_idx<=t and w_valid<=1, shift new into the window, t<=t+1.
  - No bubbles: with w_ready held high, one word is issued per cycle.
- Sigma functions:
  - MODE 224/256: s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
  - MODE 384/512: s0 = ROTR1^ROTR8^SHR7; s1 = ROTR19^ROTR61^SHR6.
- w_last is registered with w_data and equals (w_idx == R-1).
- End of block: when the word with w_last=1 is accepted, state<=LOAD and t<=0, in that same cycle. The first word of the next block may be accepted on the following cycle. Throughput is exactly R handshakes per block.
- clr (highest priority below reset):
  - Next edge: state=LOAD, t=0, w_valid=0, w_last=0.
  - Window contents are don't-care.
  - An m handshake in the same cycle is discarded.
- Reset asserted mid-block: immediate return to the reset values; the partial block is lost and no word is emitted for it.
- Latency: m_data accepted at edge N appears on w_data after edge N, unmodified.

Test Plan:
- SHA-256 "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), w_ready=1 -> w_data 0..15 equal the inputs; W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; w_last only at w_idx=63; 64 words total.
- SHA-512 (MODE=512, WIDTH=64) "abc" (M0=0x6162638000000000, M15=0x18) -> W16=0x6162638000000000, W17=0x00030000000000C0; w_last at w_idx=79.
- Backpressure: w_ready low for 5 cycles at t=3 and at t=40 -> w_data/w_idx held stable, m_ready=0 during the stall at t=3; the sequence is identical to the no-stall run.
- Back-to-back blocks with m_valid always high -> first word of block 2 accepted the cycle after block 1's w_last handshake; block 2's W matches an independent run.
- Async rst_n pulse at t=30 mid-EXPAND -> w_valid=0 immediately; the next block loaded afterwards yields the correct schedule.
- clr at t=10 (LOAD) and at t=50 (EXPAND) -> w_valid=0 next cycle, m_ready=1 afterwards, w_idx restarts at 0.
